mem_access_unit: RTL
====================

# mem_access_unit

Load/store sequencer between the multicycle controller/datapath and `dmem`.
- Accepts one memory request per handshake, converts byte address, size and signedness into word-aligned `dmem` accesses with byte enables, and lane-shifts store data.
- Splits word/halfword accesses that cross a 32-bit boundary into two `dmem` cycles.
- Extracts and sign/zero-extends load data and returns it with a one-cycle `done` pulse.

## Interface
Parameters:
- `AW`, 32, byte-address width.
- `DW`, 32, data width; fixed at 32, four byte lanes.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in 1: request valid; accepted only when `ready`=1.
- `ready` out 1: high only in IDLE.
- `wr` in 1: 1=store, 0=load.
- `size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `sgn` in 1: loads only; 1=sign-extend, 0=zero-extend.
- `addr` in AW: byte address, little-endian.
- `wdata` in DW: store data, right-justified.
- `done` out 1: one-cycle completion pulse.
- `rdata` out DW: load result; holds until next `done`.
- `err` out 1: valid with `done`; 1 for illegal size.
- `mem_we` out 1: to `dmem.we`.
- `mem_a` out AW: to `dmem.a`; always word-aligned, bits [1:0]=00.
- `mem_be` out 4: to `dmem.be`.
- `mem_wd` out DW: to `dmem.wd`.
- `mem_op` out 2: to `dmem.op`; held at 2'b01 (raw word read).
- `mem_op2` out 2: to `dmem.op2`; held at 2'b00.
- `mem_rd` in DW: from `dmem.rd`; combinational read of `mem_a`.

## Operation
- FSM states:
  - IDLE: on `req`, latch `wr`, `size`, `sgn`, `addr`, `wdata` → ACC0, or → RESP if `size`=11.
  - ACC0 → ACC1 if split, else → RESP.
  - ACC1 → RESP.
  - RESP → IDLE.
- Definitions: `off`=`addr[1:0]`; `nb`=1/2/4 for byte/half/word.
- Split condition: `off`+`nb` > 4. Possible only for half at off=3, or word at off≠0.
- 8-lane mask `m8` = ((1<<nb)-1) << off. 64-bit data `d64` = `wdata` << (8*off).
- ACC0 drives:
  - `mem_a`={addr[31:2],00}
  - `mem_be`=`m8[3:0]`
  - `mem_wd`=`d64[31:0]`
  - `mem_we`=`wr`
- ACC1 drives:
  - `mem_a`={addr[31:2],00}+4, modulo 2^32 (0xFFFFFFFC wraps to 0).
  - `mem_be`=`m8[7:4]`
  - `mem_wd`=`d64[63:32]`
  - `mem_we`=`wr`
- Loads:
  - `mem_rd` is captured at the end of ACC0 into `lo` and at the end of ACC1 into `hi`.
  - Result = ({hi,lo} >> 8*off), truncated to `nb` bytes, then extended per `sgn`.
  - `sgn` is ignored for word loads.
  - `rdata` updates at entry to RESP. Stores leave `rdata` unchanged.
- Illegal size: no `dmem` access; `rdata`=0, `err`=1.
- Outside ACC0/ACC1: `mem_we`=0, `mem_be`=0, `mem_a`=0, `mem_wd`=0.
- `req` while not `ready`: ignored, not queued.

## Timing
- Request accepted at posedge N (IDLE, `req`=1).
- Aligned access: ACC0 in cycle N..N+1, `done` in cycle N+2.
- Split access: ACC1 in cycle N+1..N+2, `done` in cycle N+3.
- Illegal size: `done`+`err` in cycle N+1.
- `ready` goes low the cycle after acceptance and rises in the cycle after `done`. Back-to-back requests: one per 3 (aligned) or 4 (split) cycles.
- Each `dmem` write occurs at the posedge ending its ACC cycle.
- Reset values: state IDLE, `ready`=1, `done`=0, `err`=0, `rdata`=0, `mem_we`=0, `mem_be`=0, `mem_a`=0, `mem_wd`=0, `mem_op`=01, `mem_op2`=00.
- Reset mid-operation:
  - `mem_we` drops immediately (asynchronous).
  - Any remaining ACC1 write is not issued. A completed ACC0 write stays in memory.
  - No `done` is generated.

## Structure
- `mem_pkg`:
  - `size_e` enum (BYTE, HALF, WORD, ILL)
  - `mau_state_e` enum (IDLE, ACC0, ACC1, RESP)
  - constants for `dmem` op codes (OP_RAW=2'b01, OP2_NONE=2'b00)
- Sub-module `lane_align`, combinational:
  - store side: computes `m8` and `d64` from `size`/`off`/`wdata`.
  - load side: computes the extracted, extended result from {hi,lo}/`off`/`size`/`sgn`.
- `mem_access_unit` holds the FSM, request latches and `lo`/`hi` capture.

## Test plan
- Word store to 0x3C with `wdata`=0x000F4240, then load word from 0x3C → one ACC each; `mem_be`=1111; `rdata`=0x000F4240; `done` at N+2.
- Byte store 0xFF to 0x29, then signed byte load → `mem_a`=0x28, `mem_be`=0010; `rdata`=0xFFFFFFFF. Same load with `sgn`=0 → `rdata`=0x000000FF.
- Word store 0x11223344 to 0x3E → ACC0 `mem_a`=0x3C, `mem_be`=1100, `mem_wd`=0x33440000; ACC1 `mem_a`=0x40, `mem_be`=0011, `mem_wd`=0x00001122. Load word 0x3E → 0x11223344, `done` at N+3.
- Signed half load at 0xFFFFFFFF, with byte 0xFFFFFFFF=0x80 and byte 0x0=0x7F → ACC1 `mem_a`=0x00000000; `rdata`=0x00007F80.
- `size`=11 → no `mem_we`/`mem_be` activity; `done`=1, `err`=1, `rdata`=0 at N+1.
- Assert `reset_n`=0 during ACC1 of a split store → `mem_we`=0 immediately; ACC0 bytes present, ACC1 bytes unchanged; `ready`=1, `done` never pulses.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// mem_pkg : shared types and dmem op codes for mem_access_unit (rev 1.0)
// ----------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC0 = 2'b01,
    ACC1 = 2'b10,
    RESP = 2'b11
  } mau_state_e;

  localparam logic [1:0] OP_RAW   = 2'b01;
  localparam logic [1:0] OP2_NONE = 2'b00;

endpackage
`default_nettype wire

// File: rtl/lane_align.sv
`default_nettype none
// ----------------------------------------------------------------------
// lane_align : byte-lane masks/shifts for stores, extract+extend for loads
// rev 1.0
// ----------------------------------------------------------------------
module lane_align
  import mem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic        sgn,
  input  logic [63:0] rd64,
  output logic [7:0]  m8,
  output logic [63:0] d64,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    m8      = 8'h00;
    d64     = {32'h0, wdata} << {off, 3'b000};
    shifted = 32'(rd64 >> {off, 3'b000});
    result  = 32'h0;
    case (size)
      BYTE: begin
        m8     = 8'b0000_0001 << off;
        result = {{24{sgn & shifted[7]}}, shifted[7:0]};
      end
      HALF: begin
        m8     = 8'b0000_0011 << off;
        result = {{16{sgn & shifted[15]}}, shifted[15:0]};
      end
      WORD: begin
        m8     = 8'b0000_1111 << off;
        result = shifted;
      end
      default: begin
        m8     = 8'h00;
        result = 32'h0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ----------------------------------------------------------------------
// mem_access_unit : load/store sequencer between controller and dmem
// rev 1.0
// ----------------------------------------------------------------------
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req,
  output logic          ready,
  input  logic          wr,
  input  logic [1:0]    size,
  input  logic          sgn,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [3:0]    mem_be,
  output logic [DW-1:0] mem_wd,
  output logic [1:0]    mem_op,
  output logic [1:0]    mem_op2,
  input  logic [DW-1:0] mem_rd
);

  mau_state_e    state, state_nx;
  logic          wr_q, sgn_q, err_q;
  size_e         size_q;
  logic [AW-1:0] addr_q, word_a;
  logic [DW-1:0] wdata_q, lo, rdata_q, result;
  logic [7:0]    m8;
  logic [63:0]   d64, rd64;
  logic          split;

  assign word_a = {addr_q[AW-1:2], 2'b00};
  assign split  = |m8[7:4];
  // During ACC1 the live dmem word is the high half; otherwise the access fits in one word.
  assign rd64   = (state == ACC1) ? {mem_rd, lo} : {32'h0, mem_rd};

  lane_align u_lane_align (
    .size   (size_q),
    .off    (addr_q[1:0]),
    .wdata  (wdata_q),
    .sgn    (sgn_q),
    .rd64   (rd64),
    .m8     (m8),
    .d64    (d64),
    .result (result)
  );

  always_comb begin
    state_nx = state;
    mem_we   = 1'b0;
    mem_a    = '0;
    mem_be   = 4'h0;
    mem_wd   = '0;
    case (state)
      IDLE: if (req) state_nx = (size_e'(size) == ILL) ? RESP : ACC0;
      ACC0: begin
        state_nx = split ? ACC1 : RESP;
        mem_we   = wr_q;
        mem_a    = word_a;
        mem_be   = m8[3:0];
        mem_wd   = d64[31:0];
      end
      ACC1: begin
        state_nx = RESP;
        mem_we   = wr_q;
        mem_a    = word_a + AW'(4);
        mem_be   = m8[7:4];
        mem_wd   = d64[63:32];
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      lo      <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req) begin
            wr_q    <= wr;
            sgn_q   <= sgn;
            size_q  <= size_e'(size);
            addr_q  <= addr;
            wdata_q <= wdata;
            err_q   <= (size_e'(size) == ILL);
            if (size_e'(size) == ILL) rdata_q <= '0;
          end
        end
        ACC0: begin
          lo <= mem_rd;
          if (!split && !wr_q) rdata_q <= result;
        end
        ACC1: if (!wr_q) rdata_q <= result;
        default: ;
      endcase
    end
  end

  assign ready   = (state == IDLE);
  assign done    = (state == RESP);
  assign err     = done & err_q;
  assign rdata   = rdata_q;
  assign mem_op  = OP_RAW;
  assign mem_op2 = OP2_NONE;

endmodule
`default_nettype wire
